// File: rtl/keypad_pkg.sv
// Shared types and key decoding for the 4x4 keypad scanner and the lock controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_e;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // One-cold line pattern to index, bit 3 (top row / left column) is index 0.
    function automatic logic [1:0] cold_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0111: idx = 2'd0;
            4'b1011: idx = 2'd1;
            4'b1101: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        if (c == 2'd3) begin
            code = KEY_A + {2'b00, r};
        end else if (r == 2'd3) begin
            case (c)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running divider producing a one-cycle tick on the wrap cycle.
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with press/release debounce and one strobe per press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    logic          tick;
    logic [3:0]    sync1_q, rs_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_pressed_q, key_pressed_d;
    logic          rotate, confirm, one_low;

    tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign cnt_inc = cnt_q + 1'b1;
    assign one_low = ($countones(~rs_q) == 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 4'hF;
            rs_q          <= 4'hF;
            state_q       <= SCAN;
            cnt_q         <= '0;
            pat_q         <= 4'hF;
            col_q         <= 4'b0111;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            sync1_q       <= row;
            rs_q          <= sync1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pat_q         <= pat_d;
            col_q         <= col_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        rotate  = 1'b0;
        confirm = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    // Multiple rows low is ambiguous and treated as idle.
                    if (one_low) begin
                        pat_d = rs_q;
                        if (DEBOUNCE_CNT <= 1) begin
                            confirm = 1'b1;
                            state_d = PRESSED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        rotate = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rs_q == pat_q) begin
                        if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                            confirm = 1'b1;
                            state_d = PRESSED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = SCAN;
                        cnt_d   = '0;
                        rotate  = 1'b1;
                    end
                end
                PRESSED: begin
                    if (rs_q == 4'hF) begin
                        if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                            state_d = SCAN;
                            cnt_d   = '0;
                            rotate  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_comb begin
        col_d         = rotate ? {col_q[0], col_q[3:1]} : col_q;
        key_code_d    = confirm ? keymap(cold_idx(pat_d), cold_idx(col_q)) : key_code_q;
        key_valid_d   = confirm;
        key_pressed_d = (state_d == PRESSED);
    end

    assign col         = col_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=2, DEBOUNCE_CNT=2 and static row patterns.
module tb_keypad_scan;

    typedef struct {
        logic [3:0] col;
        logic [3:0] row;
        logic [3:0] code;
    } key_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row = 4'hF;
    logic [3:0] col, key_code;
    logic       key_valid, key_pressed;

    int vectors     = 0;
    int miscompares = 0;
    int strobes     = 0;

    keypad_scan #(.SCAN_DIV(2), .DEBOUNCE_CNT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_valid === 1'b1) strobes++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_col(input logic [3:0] c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (col == c) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) ok = 1'b1;
        end
    endtask

    // The synchronizer delays row by one tick at this divider, so a pattern
    // applied while the preceding column is driven is detected on v.col.
    task automatic press(input key_vec_t v, input string name);
        bit ok;
        int base;
        wait_col({v.col[2:0], v.col[3]}, ok);
        chk({name, " prev col reached"}, 32'(ok), 1);
        base = strobes;
        row  = v.row;
        wait_valid(ok);
        chk({name, " valid seen"}, 32'(ok), 1);
        chk({name, " key_code"}, 32'(key_code), 32'(v.code));
        chk({name, " col held"}, 32'(col), 32'(v.col));
        repeat (24) @(negedge clk);
        chk({name, " pressed while held"}, 32'(key_pressed), 1);
        chk({name, " single strobe"}, 32'(strobes - base), 1);
    endtask

    task automatic release_key(input key_vec_t v, input string name);
        int n;
        n   = 0;
        row = 4'hF;
        while (key_pressed === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " release latency 3..7"}, 32'(n >= 3 && n <= 7), 1);
        chk({name, " resume next col"}, 32'(col), 32'({v.col[0], v.col[3:1]}));
        chk({name, " code held"}, 32'(key_code), 32'(v.code));
    endtask

    initial begin
        key_vec_t   keys[5];
        key_vec_t   kv;
        logic [3:0] col_seq[8];
        logic [3:0] prev;
        bit         ok;
        int         base, trans;

        keys[0] = '{col: 4'b0111, row: 4'b0111, code: 4'd1};
        keys[1] = '{col: 4'b1110, row: 4'b1110, code: 4'd13};
        keys[2] = '{col: 4'b1101, row: 4'b1110, code: 4'd15};
        keys[3] = '{col: 4'b0111, row: 4'b1110, code: 4'd14};
        keys[4] = '{col: 4'b1011, row: 4'b1011, code: 4'd5};
        col_seq = '{4'b0111, 4'b1011, 4'b1011, 4'b1101,
                    4'b1101, 4'b1110, 4'b1110, 4'b0111};

        repeat (2) @(negedge clk);
        chk("reset col", 32'(col), 32'(4'b0111));
        chk("reset key_code", 32'(key_code), 0);
        chk("reset key_valid", 32'(key_valid), 0);
        chk("reset key_pressed", 32'(key_pressed), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("idle col step %0d", i), 32'(col), 32'(col_seq[i]));
        end

        for (int i = 0; i < 5; i++) begin
            press(keys[i], $sformatf("key%0d", i));
            release_key(keys[i], $sformatf("key%0d", i));
        end

        // Bounce: low only in non-tick cycles, so no tick ever samples it.
        wait_col(4'b1101, ok);
        wait_col(4'b1110, ok);
        chk("bounce sync", 32'(ok), 1);
        base = strobes;
        for (int i = 0; i < 10; i++) begin
            row = (i % 2 == 0) ? 4'b0111 : 4'hF;
            @(negedge clk);
        end
        chk("bounce no strobe", 32'(strobes - base), 0);
        chk("bounce not pressed", 32'(key_pressed), 0);
        row = 4'b0111;
        wait_valid(ok);
        chk("bounce valid seen", 32'(ok), 1);
        chk("bounce key_code", 32'(key_code), 2);
        repeat (10) @(negedge clk);
        chk("bounce single strobe", 32'(strobes - base), 1);
        kv = '{col: 4'b1011, row: 4'b0111, code: 4'd2};
        release_key(kv, "bounce");

        // Two rows low: ignored, columns keep rotating every 2 cycles.
        base = strobes;
        row  = 4'b0011;
        prev = col;
        trans = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (col != prev) trans++;
            prev = col;
        end
        chk("multi-row col transitions", 32'(trans), 10);
        chk("multi-row no strobe", 32'(strobes - base), 0);
        row = 4'hF;
        repeat (4) @(negedge clk);

        // Reset while held; key 2 sits in the column re-detected after reset.
        press(kv, "rstkey");
        rst = 1'b1;
        #1;
        chk("midpress rst col", 32'(col), 32'(4'b0111));
        chk("midpress rst key_code", 32'(key_code), 0);
        chk("midpress rst key_valid", 32'(key_valid), 0);
        chk("midpress rst key_pressed", 32'(key_pressed), 0);
        repeat (2) @(negedge clk);
        base = strobes;
        rst  = 1'b0;
        wait_valid(ok);
        chk("re-detect valid seen", 32'(ok), 1);
        chk("re-detect key_code", 32'(key_code), 2);
        repeat (20) @(negedge clk);
        chk("re-detect single strobe", 32'(strobes - base), 1);
        chk("re-detect pressed", 32'(key_pressed), 1);
        release_key(kv, "re-detect");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
